video_fetch: RTL and testbench

VIDEO_FETCH -- requirements
Module: video_fetch

---
 rtl/cgia_pkg.sv | 14 +
 rtl/video_fifo.sv | 68 ++++++
 rtl/video_fetch.sv | 168 ++++++++++++++++
 tb/tb_video_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgia_pkg.sv
// Shared widths, default buffer depth and fetch FSM encoding for the video
// fetch path.
package cgia_pkg;

    localparam int WORD_W             = 16;
    localparam int ADR_W              = 16;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/video_fifo.sv
// Small synchronous prefetch FIFO; the head word is visible combinationally so
// the serializer can load it in the same cycle it pops.
module video_fifo
    import cgia_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/video_fetch.sv
// Line-based video word fetcher: prefetches stride words per line into a small
// FIFO and serializes them MSB-first as 1bpp pixels during display enable.
module video_fetch
    import cgia_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              dotclk_i,
    input  logic              reset_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              hden_i,
    input  logic              vden_i,
    input  logic [ADR_W-1:0]  base_i,
    input  logic [7:0]        stride_i,
    output logic [ADR_W-1:0]  adr_o,
    output logic              req_o,
    input  logic              ack_i,
    input  logic [WORD_W-1:0] dat_i,
    output logic              pixel_o,
    output logic              de_o,
    output logic              underrun_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state_reg;
    logic              hsync_prev_reg;
    logic              vsync_prev_reg;
    logic [ADR_W-1:0]  line_adr_reg;
    logic [ADR_W-1:0]  fetch_adr_reg;
    logic [7:0]        words_left_reg;
    logic              discard_reg;
    logic              req_reg;
    logic [ADR_W-1:0]  adr_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [3:0]        bit_cnt_reg;
    logic              pixel_reg;
    logic              de_reg;
    logic              underrun_reg;

    logic              hs_rise;
    logic              vs_rise;
    logic              active;
    logic [ADR_W-1:0]  line_base;
    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    assign hs_rise   = hsync_i & ~hsync_prev_reg;
    assign vs_rise   = vsync_i & ~vsync_prev_reg;
    assign active    = hden_i & vden_i;
    // A coincident vsync rise makes this line start from the new frame base.
    assign line_base = vs_rise ? base_i : line_adr_reg;
    // Data for a request that straddled a line start belongs to the old line.
    assign fifo_push = (state_reg == ST_REQ) & ack_i & ~discard_reg & ~hs_rise & ~fifo_full;
    assign fifo_pop  = active & (bit_cnt_reg == 4'd0) & ~fifo_empty;

    assign adr_o      = adr_reg;
    assign req_o      = req_reg;
    assign pixel_o    = pixel_reg;
    assign de_o       = de_reg;
    assign underrun_o = underrun_reg;

    video_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (dotclk_i),
        .rst_n (reset_i),
        .clr   (hs_rise),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (dat_i),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge dotclk_i or negedge reset_i) begin
        if (!reset_i) begin
            hsync_prev_reg <= 1'b0;
            vsync_prev_reg <= 1'b0;
            line_adr_reg   <= '0;
            fetch_adr_reg  <= '0;
            words_left_reg <= '0;
            state_reg      <= ST_IDLE;
            discard_reg    <= 1'b0;
            req_reg        <= 1'b0;
            adr_reg        <= '0;
        end else begin
            hsync_prev_reg <= hsync_i;
            vsync_prev_reg <= vsync_i;
            if (hs_rise) begin
                fetch_adr_reg  <= line_base;
                words_left_reg <= stride_i;
                line_adr_reg   <= line_base + ADR_W'(stride_i);
            end else begin
                if (vs_rise) begin
                    line_adr_reg <= base_i;
                end
                if (fifo_push) begin
                    fetch_adr_reg  <= fetch_adr_reg + ADR_W'(1);
                    words_left_reg <= words_left_reg - 8'd1;
                end
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!hs_rise && words_left_reg != 8'd0 &&
                        fifo_count < CNT_W'(FIFO_DEPTH)) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                        adr_reg   <= fetch_adr_reg;
                    end
                end
                ST_REQ: begin
                    if (ack_i) begin
                        state_reg   <= ST_IDLE;
                        req_reg     <= 1'b0;
                        discard_reg <= 1'b0;
                    end else if (hs_rise) begin
                        discard_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dotclk_i or negedge reset_i) begin
        if (!reset_i) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            pixel_reg    <= 1'b0;
            de_reg       <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            de_reg    <= active;
            pixel_reg <= 1'b0;
            if (vs_rise) begin
                underrun_reg <= 1'b0;
            end
            if (active) begin
                if (bit_cnt_reg == 4'd0) begin
                    if (!fifo_empty) begin
                        pixel_reg   <= fifo_dout[WORD_W-1];
                        shift_reg   <= {fifo_dout[WORD_W-2:0], 1'b0};
                        bit_cnt_reg <= 4'd15;
                    end else begin
                        underrun_reg <= 1'b1;
                    end
                end else begin
                    pixel_reg   <= shift_reg[WORD_W-1];
                    shift_reg   <= {shift_reg[WORD_W-2:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg - 4'd1;
                end
            end
            if (hs_rise) begin
                bit_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_fetch.sv
// Self-checking bench for video_fetch: table-driven line vectors plus
// hand-written sequences for stalled acks, buffer fill limit and async reset.
module tb_video_fetch;

    localparam int DEPTH = 4;

    logic        dotclk_i = 1'b0;
    logic        reset_i;
    logic        hsync_i, vsync_i, hden_i, vden_i;
    logic [15:0] base_i;
    logic [7:0]  stride_i;
    logic [15:0] adr_o;
    logic        req_o;
    logic        ack_i;
    logic [15:0] dat_i;
    logic        pixel_o, de_o, underrun_o;

    always #5 dotclk_i = ~dotclk_i;

    video_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .dotclk_i   (dotclk_i),
        .reset_i    (reset_i),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .hden_i     (hden_i),
        .vden_i     (vden_i),
        .base_i     (base_i),
        .stride_i   (stride_i),
        .adr_o      (adr_o),
        .req_o      (req_o),
        .ack_i      (ack_i),
        .dat_i      (dat_i),
        .pixel_o    (pixel_o),
        .de_o       (de_o),
        .underrun_o (underrun_o)
    );

    typedef struct {
        int          vs;         // 0 none, 1 vsync then hsync, 2 both in one cycle
        logic [15:0] base;
        logic [7:0]  stride;
        int          n_active;
        bit          exp_req;
        logic [15:0] exp_first;
        bit          chk_word;
        logic [15:0] exp_word;
        logic        exp_und;
    } vec_t;

    vec_t        vecs [7];
    int          checks = 0;
    int          errors = 0;

    // reference model / scoreboard state
    logic [15:0] exp_adr [$];
    logic [15:0] fifo_m [$];
    logic [15:0] req_log [$];
    logic [15:0] line_m, shift_m, held_adr;
    int          cnt_m, req_cyc, ack_delay, n_acks;
    logic        und_m, disc_m, hs_prev_m, vs_prev_m, req_state_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h2000) return 16'hA5F0;
        return 16'(a * 16'd40503) ^ 16'h5AC3;
    endfunction

    task automatic model_reset();
        exp_adr.delete();
        fifo_m.delete();
        line_m = '0; shift_m = '0; held_adr = '0;
        cnt_m = 0; req_cyc = 0;
        und_m = 1'b0; disc_m = 1'b0; hs_prev_m = 1'b0; vs_prev_m = 1'b0; req_state_m = 1'b0;
    endtask

    // Advance one dot clock: predict, clock, compare, then act as the memory.
    task automatic tick();
        logic        ack_app, act, hr, vr, pix_exp;
        logic [15:0] dat_app, w;
        ack_app = ack_i;
        dat_app = dat_i;
        act = hden_i & vden_i;
        hr = hsync_i & ~hs_prev_m;
        vr = vsync_i & ~vs_prev_m;
        hs_prev_m = hsync_i;
        vs_prev_m = vsync_i;
        if (vr) begin
            line_m = base_i;
            und_m = 1'b0;
        end
        if (hr) begin
            exp_adr.delete();
            for (int i = 0; i < int'(stride_i); i++) exp_adr.push_back(16'(line_m + 16'(i)));
            line_m = 16'(line_m + {8'h00, stride_i});
            if (req_state_m) disc_m = 1'b1;
        end
        pix_exp = 1'b0;
        if (act) begin
            if (cnt_m == 0) begin
                if (fifo_m.size() > 0) begin
                    w = fifo_m.pop_front();
                    pix_exp = w[15];
                    shift_m = {w[14:0], 1'b0};
                    cnt_m = 15;
                end else begin
                    und_m = 1'b1;
                end
            end else begin
                pix_exp = shift_m[15];
                shift_m = {shift_m[14:0], 1'b0};
                cnt_m--;
            end
        end
        if (hr) begin
            cnt_m = 0;
            fifo_m.delete();
        end
        if (ack_app) begin
            n_acks++;
            if (disc_m) disc_m = 1'b0;
            else fifo_m.push_back(dat_app);
        end
        @(posedge dotclk_i);
        #1;
        chk("pixel", pixel_o, pix_exp);
        chk("de", de_o, act);
        chk("underrun", underrun_o, und_m);
        if (ack_app) chk("req_drop_after_ack", req_o, 1'b0);
        if (req_o) begin
            if (req_cyc == 0) begin
                req_log.push_back(adr_o);
                $display("request adr 0x%04h", adr_o);
                if (exp_adr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got adr 0x%0h, expected no request", adr_o);
                end else begin
                    chk("req_adr", adr_o, exp_adr.pop_front());
                end
                held_adr = adr_o;
            end else begin
                chk("adr_stable", adr_o, held_adr);
            end
            if (req_cyc >= ack_delay) begin
                ack_i = 1'b1;
                dat_i = mem_word(adr_o);
            end else begin
                ack_i = 1'b0;
            end
            req_cyc++;
        end else begin
            ack_i = 1'b0;
            req_cyc = 0;
        end
        req_state_m = req_o;
    endtask

    task automatic pulse(input bit v, input bit h, input logic [15:0] b, input logic [7:0] s);
        base_i = b;
        stride_i = s;
        vsync_i = v;
        hsync_i = h;
        tick();
        vsync_i = 1'b0;
        hsync_i = 1'b0;
    endtask

    task automatic wait_fetch(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            tick();
            if (!req_o && !ack_i && (exp_adr.size() == 0 || fifo_m.size() >= DEPTH)) done = 1'b1;
        end
        chk({name, "_fetch_settled"}, done, 1'b1);
    endtask

    task automatic wait_req(input string name);
        for (int n = 0; n < 20 && !req_o; n++) tick();
        chk({name, "_req_seen"}, req_o, 1'b1);
    endtask

    task automatic run_active(input int n, output logic [15:0] cap);
        cap = '0;
        hden_i = 1'b1;
        vden_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i < 16) cap = {cap[14:0], pixel_o};
        end
        hden_i = 1'b0;
        vden_i = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          nb;
        logic [15:0] cap;
        reset_i = 1'b0;
        hsync_i = 1'b0; vsync_i = 1'b0; hden_i = 1'b0; vden_i = 1'b0;
        base_i = '0; stride_i = '0; ack_i = 1'b0; dat_i = '0;
        ack_delay = 0; n_acks = 0;
        model_reset();

        vecs[0] = '{1, 16'h1000, 8'd3, 0,  1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{0, 16'h0000, 8'd3, 48, 1'b1, 16'h1003, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{2, 16'h2000, 8'd1, 17, 1'b1, 16'h2000, 1'b1, 16'hA5F0, 1'b1};
        vecs[3] = '{1, 16'h3000, 8'd0, 2,  1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{0, 16'h0000, 8'd2, 40, 1'b1, 16'h3000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{1, 16'hFFFE, 8'd4, 64, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{0, 16'h0000, 8'd5, 80, 1'b1, 16'h0002, 1'b0, 16'h0000, 1'b0};

        repeat (3) @(posedge dotclk_i);
        #1;
        chk("rst_req", req_o, 1'b0);
        chk("rst_adr", adr_o, 16'h0000);
        chk("rst_pixel", pixel_o, 1'b0);
        chk("rst_de", de_o, 1'b0);
        chk("rst_underrun", underrun_o, 1'b0);
        @(negedge dotclk_i);
        reset_i = 1'b1;
        repeat (2) tick();

        foreach (vecs[vi]) begin
            $display("vector %0d: base 0x%04h stride %0d active %0d", vi, vecs[vi].base,
                     vecs[vi].stride, vecs[vi].n_active);
            nb = req_log.size();
            if (vecs[vi].vs == 1) begin
                pulse(1'b1, 1'b0, vecs[vi].base, vecs[vi].stride);
                pulse(1'b0, 1'b1, vecs[vi].base, vecs[vi].stride);
            end else begin
                pulse(vecs[vi].vs == 2, 1'b1, vecs[vi].base, vecs[vi].stride);
            end
            if (vecs[vi].vs != 0) chk($sformatf("v%0d_underrun_cleared", vi), underrun_o, 1'b0);
            wait_fetch($sformatf("v%0d", vi));
            if (vecs[vi].exp_req) begin
                chk($sformatf("v%0d_req_issued", vi), req_log.size() > nb, 1'b1);
                if (req_log.size() > nb)
                    chk($sformatf("v%0d_first_adr", vi), req_log[nb], vecs[vi].exp_first);
            end else begin
                chk($sformatf("v%0d_no_req", vi), req_log.size(), nb);
            end
            repeat (4) tick();
            run_active(vecs[vi].n_active, cap);
            if (vecs[vi].chk_word) chk($sformatf("v%0d_pixel_word", vi), cap, vecs[vi].exp_word);
            repeat (3) tick();
            chk($sformatf("v%0d_underrun_end", vi), underrun_o, vecs[vi].exp_und);
        end

        // Stalled ack with a new line starting while the request is pending.
        $display("sequence: stalled ack across hsync");
        ack_delay = 10;
        nb = req_log.size();
        pulse(1'b1, 1'b0, 16'h4000, 8'd2);
        pulse(1'b0, 1'b1, 16'h4000, 8'd2);
        wait_req("s1");
        repeat (3) tick();
        pulse(1'b0, 1'b1, 16'h4000, 8'd2);
        wait_fetch("s1");
        chk("s1_req_count", req_log.size() >= nb + 2, 1'b1);
        if (req_log.size() >= nb + 2) begin
            chk("s1_old_adr", req_log[nb], 16'h4000);
            chk("s1_new_line_adr", req_log[nb + 1], 16'h4002);
        end
        run_active(32, cap);
        repeat (3) tick();
        chk("s1_underrun", underrun_o, 1'b0);
        ack_delay = 0;

        // Long line with no display: fetch stops once the buffer is full.
        $display("sequence: buffer fill limit");
        pulse(1'b1, 1'b0, 16'h5000, 8'd8);
        nb = n_acks;
        pulse(1'b0, 1'b1, 16'h5000, 8'd8);
        repeat (40) tick();
        chk("s2_acks_full", n_acks - nb, 4);
        chk("s2_req_idle", req_o, 1'b0);
        run_active(1, cap);
        repeat (20) tick();
        chk("s2_acks_after_pop", n_acks - nb, 5);

        // Async reset in the middle of a request.
        $display("sequence: async reset mid-request");
        ack_delay = 5;
        pulse(1'b0, 1'b1, 16'h5000, 8'd2);
        wait_req("s3");
        repeat (2) tick();
        #2;
        reset_i = 1'b0;
        #1;
        chk("s3_rst_req", req_o, 1'b0);
        chk("s3_rst_adr", adr_o, 16'h0000);
        chk("s3_rst_pixel", pixel_o, 1'b0);
        chk("s3_rst_de", de_o, 1'b0);
        chk("s3_rst_underrun", underrun_o, 1'b0);
        ack_i = 1'b0;
        model_reset();
        @(negedge dotclk_i);
        reset_i = 1'b1;
        ack_delay = 0;
        nb = req_log.size();
        repeat (20) tick();
        chk("s3_no_fetch_after_reset", req_log.size(), nb);
        pulse(1'b0, 1'b1, 16'h7000, 8'd1);
        wait_fetch("s3");
        chk("s3_req_after_hsync", req_log.size() > nb, 1'b1);
        if (req_log.size() > nb) chk("s3_line_adr_cleared", req_log[nb], 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
